// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO hub: unit codes, register offsets,
// reset constants and the decoded coprocessor address bundle.
package mmio_pkg;

    typedef logic [1:0] player_t;

    // Coprocessor-space address fields after the MSB has been stripped.
    typedef struct packed {
        logic       cop;
        logic [2:0] unit;
        player_t    pl;
        logic [4:0] rg;
    } cop_addr_t;

    localparam logic [2:0] UNIT_PHYS = 3'd0;
    localparam logic [2:0] UNIT_CTRL = 3'd1;
    localparam logic [2:0] UNIT_COLL = 3'd2;
    localparam logic [2:0] UNIT_ATK  = 3'd3;
    localparam logic [2:0] UNIT_CFG  = 3'd4;

    localparam logic [4:0] REG_SNAP   = 5'd0;
    localparam logic [4:0] REG_KNOCK  = 5'd1;
    localparam logic [4:0] REG_MASS   = 5'd0;
    localparam logic [4:0] REG_START  = 5'd1;
    localparam logic [4:0] REG_SIZE   = 5'd2;
    localparam logic [4:0] REG_TARGET = 5'd3;
    localparam logic [4:0] REG_GRAV   = 5'd8;
    localparam logic [4:0] REG_WIND   = 5'd9;
    localparam logic [4:0] REG_STPOS  = 5'd10;
    localparam logic [4:0] REG_STSIZE = 5'd11;

    localparam logic [31:0] GRAVITY_RST = 32'h0001_0000;
    localparam logic [31:0] WIND_RST    = 32'h0000_0010;
    localparam logic [31:0] STPOS_RST   = 32'h0143_0014;
    localparam logic [31:0] STSIZE_RST  = 32'h01FA_00C8;
    localparam logic [31:0] MASS_RST    = 32'h0000_0010;
    localparam logic [31:0] SIZE0_RST   = 32'h0085_007D;
    localparam logic [31:0] SIZE_RST    = 32'h0059_0055;

    function automatic logic [31:0] start_pos_rst(input int p);
        logic [31:0] v;
        case (p)
            0:       v = 32'h0160_00FA;
            1:       v = 32'h02A9_00FA;
            2:       v = 32'h01D0_00FA;
            default: v = 32'h0238_00FA;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mmio_cfg_regs.sv
// Software-writable game constant bank with its reset values.
// Ports: clock/reset, one pre-qualified write port, all constants out.
module mmio_cfg_regs
    import mmio_pkg::*;
#(
    parameter int N_PLAYERS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  player_t                wr_player,
    input  logic [4:0]             wr_reg,
    input  logic [31:0]            wr_data,
    output logic [31:0]            gravity,
    output logic [31:0]            wind,
    output logic [31:0]            stage_pos,
    output logic [31:0]            stage_size,
    output logic [N_PLAYERS*32-1:0] mass,
    output logic [N_PLAYERS*32-1:0] start_pos,
    output logic [N_PLAYERS*32-1:0] size,
    output logic [N_PLAYERS*2-1:0]  target
);

    // The caller only asserts wr_en for a mapped location, so globals
    // and per-player offsets can be matched independently here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gravity    <= GRAVITY_RST;
            wind       <= WIND_RST;
            stage_pos  <= STPOS_RST;
            stage_size <= STSIZE_RST;
            for (int i = 0; i < N_PLAYERS; i++) begin
                mass[32*i +: 32]      <= MASS_RST;
                start_pos[32*i +: 32] <= start_pos_rst(i);
                size[32*i +: 32]      <= (i == 0) ? SIZE0_RST : SIZE_RST;
                target[2*i +: 2]      <= 2'((i + 1) % N_PLAYERS);
            end
        end else if (wr_en) begin
            case (wr_reg)
                REG_GRAV:   gravity    <= wr_data;
                REG_WIND:   wind       <= wr_data;
                REG_STPOS:  stage_pos  <= wr_data;
                REG_STSIZE: stage_size <= wr_data;
                default: ;
            endcase
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (int'(wr_player) == i) begin
                    case (wr_reg)
                        REG_MASS:   mass[32*i +: 32]      <= wr_data;
                        REG_START:  start_pos[32*i +: 32] <= wr_data;
                        REG_SIZE:   size[32*i +: 32]      <= wr_data;
                        REG_TARGET: target[2*i +: 2]      <= wr_data[1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// MMIO hub: CPU load/store decode, per-frame coprocessor snapshot,
// attack target routing, config bank and registered read mux.
// Ports: CPU bus, dmem side, live coprocessor inputs, constants,
// snapshots, routed physics inputs and the illegal-write counter.
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int ADDR_W    = 13,
    parameter int ERR_W     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic [31:0]             data_in,
    input  logic                    wren,
    input  logic                    rden,
    output logic [31:0]             data_out,
    output logic                    rd_valid,
    input  logic [31:0]             dmem_q,
    output logic                    dmem_wren,
    input  logic                    frame_tick,
    input  logic [N_PLAYERS*32-1:0] pos_live,
    input  logic [N_PLAYERS*32-1:0] ctrl_live,
    input  logic [N_PLAYERS*32-1:0] attack_live,
    input  logic [N_PLAYERS*32-1:0] knock_live,
    input  logic [N_PLAYERS*4-1:0]  coll_live,
    output logic [31:0]             gravity,
    output logic [31:0]             wind,
    output logic [31:0]             stage_pos,
    output logic [31:0]             stage_size,
    output logic [N_PLAYERS*32-1:0] mass,
    output logic [N_PLAYERS*32-1:0] start_pos,
    output logic [N_PLAYERS*32-1:0] size,
    output logic [N_PLAYERS*32-1:0] snap_pos,
    output logic [N_PLAYERS*32-1:0] snap_ctrl,
    output logic [N_PLAYERS*32-1:0] snap_attack,
    output logic [N_PLAYERS*4-1:0]  snap_coll,
    output logic [N_PLAYERS*32-1:0] phys_knock,
    output logic [N_PLAYERS-1:0]    phys_attack,
    output logic [ERR_W-1:0]        err_count
);

    cop_addr_t                 ca;
    logic                      p_ok;
    logic                      cfg_hit;
    logic                      cfg_wr;
    logic                      err_wr;
    logic [31:0]               rd_data;
    logic [N_PLAYERS*32-1:0]   snap_knock;
    logic [N_PLAYERS*2-1:0]    target;
    logic [1:0]                unused_addr;

    assign ca.cop  = address[ADDR_W-1];
    assign ca.unit = address[11:9];
    assign ca.pl   = address[8:7];
    assign ca.rg   = address[6:2];
    assign unused_addr = address[1:0];

    assign p_ok = int'(ca.pl) < N_PLAYERS;

    // Per-player registers need a live player; globals exist only at p=0.
    always_comb begin
        cfg_hit = 1'b0;
        if (ca.unit == UNIT_CFG) begin
            if (p_ok && ca.rg <= REG_TARGET)
                cfg_hit = 1'b1;
            if (ca.pl == 2'd0 && ca.rg >= REG_GRAV && ca.rg <= REG_STSIZE)
                cfg_hit = 1'b1;
        end
    end

    assign cfg_wr    = wren & ca.cop & cfg_hit;
    assign err_wr    = wren & ca.cop & ~cfg_hit;
    assign dmem_wren = wren & ~ca.cop;

    mmio_cfg_regs #(
        .N_PLAYERS (N_PLAYERS)
    ) u_cfg (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (cfg_wr),
        .wr_player  (ca.pl),
        .wr_reg     (ca.rg),
        .wr_data    (data_in),
        .gravity    (gravity),
        .wind       (wind),
        .stage_pos  (stage_pos),
        .stage_size (stage_size),
        .mass       (mass),
        .start_pos  (start_pos),
        .size       (size),
        .target     (target)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_pos    <= '0;
            snap_ctrl   <= '0;
            snap_attack <= '0;
            snap_knock  <= '0;
            snap_coll   <= '0;
        end else if (frame_tick) begin
            snap_pos    <= pos_live;
            snap_ctrl   <= ctrl_live;
            snap_attack <= attack_live;
            snap_knock  <= knock_live;
            snap_coll   <= coll_live;
        end
    end

    // Stored targets are taken mod N_PLAYERS so any 2-bit value is legal.
    always_comb begin
        phys_knock  = '0;
        phys_attack = '0;
        for (int t = 0; t < N_PLAYERS; t++) begin
            for (int p = 0; p < N_PLAYERS; p++) begin
                if (p != t && (int'(target[2*p +: 2]) % N_PLAYERS) == t) begin
                    phys_knock[32*t +: 32] |= snap_knock[32*p +: 32];
                    phys_attack[t]         |= snap_attack[32*p];
                end
            end
        end
    end

    logic [31:0] s_pos;
    logic [31:0] s_ctrl;
    logic [31:0] s_atk;
    logic [31:0] s_knock;
    logic [3:0]  s_coll;
    logic [31:0] c_mass;
    logic [31:0] c_start;
    logic [31:0] c_size;
    logic [1:0]  c_tgt;

    always_comb begin
        s_pos   = '0;
        s_ctrl  = '0;
        s_atk   = '0;
        s_knock = '0;
        s_coll  = '0;
        c_mass  = '0;
        c_start = '0;
        c_size  = '0;
        c_tgt   = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (int'(ca.pl) == i) begin
                s_pos   = snap_pos[32*i +: 32];
                s_ctrl  = snap_ctrl[32*i +: 32];
                s_atk   = snap_attack[32*i +: 32];
                s_knock = snap_knock[32*i +: 32];
                s_coll  = snap_coll[4*i +: 4];
                c_mass  = mass[32*i +: 32];
                c_start = start_pos[32*i +: 32];
                c_size  = size[32*i +: 32];
                c_tgt   = target[2*i +: 2];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (!ca.cop) begin
            rd_data = dmem_q;
        end else if (p_ok) begin
            case (ca.unit)
                UNIT_PHYS: if (ca.rg == REG_SNAP) rd_data = s_pos;
                UNIT_CTRL: if (ca.rg == REG_SNAP) rd_data = s_ctrl;
                UNIT_COLL: if (ca.rg == REG_SNAP) rd_data = {28'b0, s_coll};
                UNIT_ATK: begin
                    if (ca.rg == REG_SNAP)  rd_data = s_atk;
                    if (ca.rg == REG_KNOCK) rd_data = s_knock;
                end
                UNIT_CFG: begin
                    case (ca.rg)
                        REG_MASS:   rd_data = c_mass;
                        REG_START:  rd_data = c_start;
                        REG_SIZE:   rd_data = c_size;
                        REG_TARGET: rd_data = {30'b0, c_tgt};
                        default: ;
                    endcase
                    if (ca.pl == 2'd0) begin
                        case (ca.rg)
                            REG_GRAV:   rd_data = gravity;
                            REG_WIND:   rd_data = wind;
                            REG_STPOS:  rd_data = stage_pos;
                            REG_STSIZE: rd_data = stage_size;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Sampling rd_data at the same edge as wren gives old-value reads
    // on a same-cycle write, and pre-tick snapshots on a tick cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rden;
            if (rden)
                data_out <= rd_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            err_count <= '0;
        else if (err_wr && err_count != {ERR_W{1'b1}})
            err_count <= err_count + 1'b1;
    end

endmodule
